// File: rtl/glb_core_pc_dma_if.sv
// Read-request / read-response channel between the PC DMA and the tile switch.
// master = DMA side (issues rdrq, receives rdrs); slave = tile switch side.
interface glb_core_pc_dma_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 64
);
  logic                  rdrq_valid;
  logic [ADDR_WIDTH-1:0] rdrq_addr;
  logic                  rdrs_valid;
  logic [DATA_WIDTH-1:0] rdrs_data;

  modport master (
    output rdrq_valid,
    output rdrq_addr,
    input  rdrs_valid,
    input  rdrs_data
  );

  modport slave (
    input  rdrq_valid,
    input  rdrq_addr,
    output rdrs_valid,
    output rdrs_data
  );
endinterface

// File: rtl/glb_core_pc_dma.sv
// Parallel-configuration read initiator for one GLB tile: fetches config words and replays them as CGRA config writes.
// Optional busy-cycle counter (perf_cycles) is built only when GLB_PC_DMA_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_pulse
// REQ   | issuing read requests while credits remain
// DRAIN | all requests issued, waiting for remaining responses
// DONE  | one-cycle completion, done_pulse high
module glb_core_pc_dma #(
  parameter int ADDR_WIDTH      = 19,
  parameter int CNT_WIDTH       = 20,
  parameter int DATA_WIDTH      = 64,
  parameter int BYTE_OFFSET     = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_pulse,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_num_cfg,
  glb_core_pc_dma_if.master     rd,
  output logic                  cgra_cfg_wr_en,
  output logic [31:0]           cgra_cfg_addr,
  output logic [31:0]           cgra_cfg_data,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  err_spurious
`ifdef GLB_PC_DMA_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(1) << BYTE_OFFSET;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STRIDE - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  num_cfg;
  logic [CNT_WIDTH-1:0]  req_cnt;
  logic [CNT_WIDTH-1:0]  rsp_cnt;
  logic [OUT_W-1:0]      outstanding;
  logic                  req_fire;
  logic                  rsp_acc;

  // Credit check uses the registered count, so a response frees its credit only for the following cycle.
  assign req_fire      = (state == REQ) && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign rsp_acc       = rd.rdrs_valid && (state != IDLE) && (outstanding != '0);
  assign rd.rdrq_valid = req_fire;
  assign rd.rdrq_addr  = addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      num_cfg        <= '0;
      req_cnt        <= '0;
      rsp_cnt        <= '0;
      outstanding    <= '0;
      cgra_cfg_wr_en <= 1'b0;
      cgra_cfg_addr  <= '0;
      cgra_cfg_data  <= '0;
      busy           <= 1'b0;
      done_pulse     <= 1'b0;
      err_spurious   <= 1'b0;
`ifdef GLB_PC_DMA_PERF_EN
      perf_cycles    <= '0;
`endif
    end else begin
      cgra_cfg_wr_en <= rsp_acc;
      done_pulse     <= 1'b0;
      if (rsp_acc) begin
        cgra_cfg_addr <= rd.rdrs_data[DATA_WIDTH-1 -: 32];
        cgra_cfg_data <= rd.rdrs_data[31:0];
        rsp_cnt       <= rsp_cnt + CNT_WIDTH'(1);
      end
      if (req_fire) begin
        addr    <= addr + STRIDE;
        req_cnt <= req_cnt + CNT_WIDTH'(1);
      end
      if (req_fire && !rsp_acc)
        outstanding <= outstanding + OUT_W'(1);
      else if (!req_fire && rsp_acc)
        outstanding <= outstanding - OUT_W'(1);
`ifdef GLB_PC_DMA_PERF_EN
      if (busy)
        perf_cycles <= perf_cycles + 32'd1;
`endif
      case (state)
        IDLE: begin
          if (start_pulse) begin
            err_spurious <= 1'b0;
            busy         <= 1'b1;
`ifdef GLB_PC_DMA_PERF_EN
            perf_cycles  <= '0;
`endif
            if (cfg_num_cfg != '0) begin
              addr    <= cfg_start_addr & ALIGN_MASK;
              num_cfg <= cfg_num_cfg;
              req_cnt <= '0;
              rsp_cnt <= '0;
              state   <= REQ;
            end else begin
              done_pulse <= 1'b1;
              state      <= DONE;
            end
          end
        end
        REQ: begin
          if (req_fire && (req_cnt == num_cfg - CNT_WIDTH'(1)))
            state <= DRAIN;
        end
        DRAIN: begin
          if (rsp_acc && (rsp_cnt == num_cfg - CNT_WIDTH'(1))) begin
            done_pulse <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed after the start handling so a spurious response wins over the clear.
      if (rd.rdrs_valid && !rsp_acc)
        err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_glb_core_pc_dma.sv
// Directed bench for glb_core_pc_dma: fixed-latency in-order responder plus hand-computed expectations.
// Build with GLB_PC_DMA_PERF_EN defined to also cover perf_cycles.
module tb_glb_core_pc_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_pulse = 1'b0;
  logic [18:0] cfg_start_addr = '0;
  logic [19:0] cfg_num_cfg = '0;
  logic        cgra_cfg_wr_en;
  logic [31:0] cgra_cfg_addr;
  logic [31:0] cgra_cfg_data;
  logic        busy;
  logic        done_pulse;
  logic        err_spurious;
`ifdef GLB_PC_DMA_PERF_EN
  logic [31:0] perf_cycles;
`endif

  glb_core_pc_dma_if #(.ADDR_WIDTH(19), .DATA_WIDTH(64)) rd_if ();

  glb_core_pc_dma #(
    .ADDR_WIDTH(19), .CNT_WIDTH(20), .DATA_WIDTH(64), .BYTE_OFFSET(3), .MAX_OUTSTANDING(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_pulse    (start_pulse),
    .cfg_start_addr (cfg_start_addr),
    .cfg_num_cfg    (cfg_num_cfg),
    .rd             (rd_if),
    .cgra_cfg_wr_en (cgra_cfg_wr_en),
    .cgra_cfg_addr  (cgra_cfg_addr),
    .cgra_cfg_data  (cgra_cfg_data),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .err_spurious   (err_spurious)
`ifdef GLB_PC_DMA_PERF_EN
    ,
    .perf_cycles    (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder and monitor
  int          lat = 3;
  bit          rsp_en = 1'b1;
  logic        rsp_v = 1'b0;
  logic [63:0] rsp_d = '0;
  logic        inj_v = 1'b0;
  logic [63:0] inj_d = '0;
  assign rd_if.rdrs_valid = rsp_v | inj_v;
  assign rd_if.rdrs_data  = inj_v ? inj_d : rsp_d;

  int          pend_due[$];
  logic [18:0] pend_addr[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          rsp_total = 0;
  int          max_out = 0;

  always @(negedge clk) begin
    if (rd_if.rdrq_valid) begin
      req_log.push_back(32'(rd_if.rdrq_addr));
      req_cyc.push_back(cyc);
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(rd_if.rdrq_addr);
    end
    if (req_log.size() - rsp_total > max_out) max_out = req_log.size() - rsp_total;
    if (cgra_cfg_wr_en) begin
      wr_a.push_back(cgra_cfg_addr);
      wr_d.push_back(cgra_cfg_data);
      wr_cyc.push_back(cyc);
    end
    if (done_pulse) done_cyc.push_back(cyc);
    rsp_v = 1'b0;
    if (rsp_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rsp_v = 1'b1;
      rsp_d = {13'h0, pend_addr[0], 32'hC0DE_0000 ^ {13'h0, pend_addr[0]}};
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      rsp_total++;
    end
  end

  function automatic int ati(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] atw(logic [31:0] q[$], int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); wr_a.delete(); wr_d.delete();
    wr_cyc.delete(); done_cyc.delete(); pend_due.delete(); pend_addr.delete();
    rsp_total = 0;
    max_out = 0;
  endtask

  task automatic kick(logic [18:0] a, logic [19:0] n, output int s);
    cfg_start_addr = a;
    cfg_num_cfg    = n;
    start_pulse    = 1'b1;
    s = cyc;
    tick(1);
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) tick(1);
    check({tag, "_done_seen"}, 32'(done_cyc.size() > 0), 32'd1);
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s;

  initial begin
    tick(2);
    check("rst_rdrq_valid", 32'(rd_if.rdrq_valid), 32'd0);
    check("rst_rdrq_addr", 32'(rd_if.rdrq_addr), 32'd0);
    check("rst_wr_en", 32'(cgra_cfg_wr_en), 32'd0);
    check("rst_cfg_addr", cgra_cfg_addr, 32'd0);
    check("rst_cfg_data", cgra_cfg_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_err", 32'(err_spurious), 32'd0);
`ifdef GLB_PC_DMA_PERF_EN
    check("rst_perf", perf_cycles, 32'd0);
`endif
    reset = 1'b0;
    tick(2);

    // Basic run: 4 words from 0x100, latency 3
    clear_logs(); lat = 3;
    kick(19'h100, 20'd4, s);
    wait_done("basic", 60);
    for (int i = 0; i < 4; i++) begin
      check("basic_rq_addr", atw(req_log, i), 32'h100 + 32'(8 * i));
      check("basic_rq_cyc", ati(req_cyc, i), s + 1 + i);
      check("basic_wr_addr", atw(wr_a, i), 32'h100 + 32'(8 * i));
      check("basic_wr_data", atw(wr_d, i), 32'hC0DE_0000 ^ (32'h100 + 32'(8 * i)));
    end
    check("basic_nreq", req_log.size(), 4);
    check("basic_nwr", wr_a.size(), 4);
    check("basic_wr4_cyc", ati(wr_cyc, 3), s + 8);
    check("basic_done_cyc", ati(done_cyc, 0), s + 8);
    check("basic_ndone", done_cyc.size(), 1);
    check("basic_busy_end", 32'(busy), 32'd0);
    check("basic_err", 32'(err_spurious), 32'd0);
`ifdef GLB_PC_DMA_PERF_EN
    check("basic_perf", perf_cycles, 32'd8);
`endif

    // Credit limit: 20 words, latency 30; unaligned start is aligned down
    clear_logs(); lat = 30;
    kick(19'h205, 20'd20, s);
    wait_done("credit", 400);
    check("credit_nreq", req_log.size(), 20);
    check("credit_first_addr", atw(req_log, 0), 32'h200);
    check("credit_last_addr", atw(req_log, 19), 32'h298);
    check("credit_burst8", ati(req_cyc, 7) - ati(req_cyc, 0), 7);
    check("credit_stall", ati(req_cyc, 8) - ati(req_cyc, 0), 31);
    check("credit_max_out", max_out, 8);
    check("credit_nwr", wr_a.size(), 20);
    check("credit_last_wr", atw(wr_a, 19), 32'h298);
    check("credit_ndone", done_cyc.size(), 1);

    // Zero count
    clear_logs(); lat = 3;
    kick(19'h500, 20'd0, s);
    wait_done("zero", 10);
    check("zero_nreq", req_log.size(), 0);
    check("zero_done_cyc", ati(done_cyc, 0), s + 1);
    check("zero_ndone", done_cyc.size(), 1);
`ifdef GLB_PC_DMA_PERF_EN
    check("zero_perf", perf_cycles, 32'd1);
`endif

    // Address wrap plus manual decode responses
    clear_logs(); rsp_en = 1'b0;
    kick(19'h7FFF8, 20'd2, s);
    tick(4);
    check("wrap_nreq", req_log.size(), 2);
    check("wrap_addr0", atw(req_log, 0), 32'h7FFF8);
    check("wrap_addr1", atw(req_log, 1), 32'h0);
    check("wrap_busy_drain", 32'(busy), 32'd1);
    inj_d = 64'h0000_1234_DEAD_BEEF; inj_v = 1'b1;
    tick(1);
    inj_d = 64'h0000_0042_0000_0007;
    check("dec_wr_en", 32'(cgra_cfg_wr_en), 32'd1);
    check("dec_addr", cgra_cfg_addr, 32'h0000_1234);
    check("dec_data", cgra_cfg_data, 32'hDEAD_BEEF);
    check("dec_done_early", 32'(done_pulse), 32'd0);
    tick(1);
    inj_v = 1'b0;
    check("dec2_addr", cgra_cfg_addr, 32'h42);
    check("dec2_data", cgra_cfg_data, 32'h7);
    check("dec2_done", 32'(done_pulse), 32'd1);
    tick(1);
    check("dec_done_once", 32'(done_pulse), 32'd0);
    check("dec_idle", 32'(busy), 32'd0);
    check("dec_err", 32'(err_spurious), 32'd0);
    tick(2);
    clear_logs(); rsp_en = 1'b1;

    // start_pulse during REQ is ignored
    lat = 3;
    kick(19'h300, 20'd3, s);
    cfg_start_addr = 19'h800; cfg_num_cfg = 20'd10; start_pulse = 1'b1;
    tick(1);
    start_pulse = 1'b0;
    wait_done("ign", 60);
    check("ign_nreq", req_log.size(), 3);
    check("ign_last_addr", atw(req_log, 2), 32'h310);
    check("ign_nwr", wr_a.size(), 3);
    check("ign_ndone", done_cyc.size(), 1);

    // Unsolicited response in IDLE, then an honoured start clears the flag
    clear_logs();
    inj_d = 64'h0000_0055_0000_0066; inj_v = 1'b1;
    tick(1);
    inj_v = 1'b0;
    check("spur_err", 32'(err_spurious), 32'd1);
    check("spur_wr_en", 32'(cgra_cfg_wr_en), 32'd0);
    tick(1);
    check("spur_nwr", wr_a.size(), 0);
    kick(19'h0, 20'd0, s);
    check("spur_clear", 32'(err_spurious), 32'd0);
    wait_done("spur", 10);

    // Reset after 3 of 10 requests; late responses are spurious
    clear_logs(); lat = 20;
    kick(19'h400, 20'd10, s);
    for (int i = 0; i < 50 && req_log.size() < 3; i++) tick(1);
    check("mid_reached3", req_log.size(), 3);
    reset = 1'b1;
    #1;
    check("mid_rdrq_valid", 32'(rd_if.rdrq_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_wr_en", 32'(cgra_cfg_wr_en), 32'd0);
    check("mid_cfg_addr", cgra_cfg_addr, 32'd0);
    check("mid_cfg_data", cgra_cfg_data, 32'd0);
    check("mid_done", 32'(done_pulse), 32'd0);
`ifdef GLB_PC_DMA_PERF_EN
    check("mid_perf", perf_cycles, 32'd0);
`endif
    tick(2);
    reset = 1'b0;
    check("mid_err_before", 32'(err_spurious), 32'd0);
    tick(30);
    check("mid_err_late", 32'(err_spurious), 32'd1);
    check("mid_nwr", wr_a.size(), 0);
    check("mid_nreq", req_log.size(), 3);

    // Clean run after reset, latency 1
    clear_logs(); lat = 1;
    kick(19'h10, 20'd3, s);
    wait_done("post", 40);
    check("post_done_cyc", ati(done_cyc, 0), s + 5);
    check("post_nwr", wr_a.size(), 3);
    check("post_wr2", atw(wr_a, 2), 32'h20);
    check("post_err", 32'(err_spurious), 32'd0);
`ifdef GLB_PC_DMA_PERF_EN
    check("post_perf", perf_cycles, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
